wb_regfile: RTL
===============

# wb_regfile

Writeback stage and architectural register file of the five-stage MIPS pipeline. Consumes the MEM/WB pipeline register outputs, selects the writeback value (load data or ALU result) and commits it to a 32 x 32-bit register file. Provides two combinational read ports to the decode stage and exports the writeback value to the EX-stage forwarding unit. Register $0 is hardwired to zero.

## Interface
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register address width (2^ADDR_W registers)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- dout_WB  in  DATA_W  load data from the MEM/WB register
- ALUResult_WB  in  DATA_W  ALU result from the MEM/WB register
- RdOrRt_WB  in  ADDR_W  destination register
- RegWrite_WB  in  1  write enable
- MemtoReg_WB  in  1  1 = write dout_WB, 0 = write ALUResult_WB
- rs_addr  in  ADDR_W  read port A address (decode)
- rt_addr  in  ADDR_W  read port B address (decode)
- rs_data  out  DATA_W  read port A data, combinational
- rt_data  out  DATA_W  read port B data, combinational
- WriteData_WB  out  DATA_W  selected writeback value, combinational, to forwarding unit
- wb_active  out  1  combinational; RegWrite_WB & (RdOrRt_WB != 0) & ~reset

## Operation
- WriteData_WB = MemtoReg_WB ? dout_WB : ALUResult_WB; valid whether or not RegWrite_WB is set.
- Commit: at rising clk, if wb_active, regs[RdOrRt_WB] <= WriteData_WB; otherwise no register changes.
- Writes to $0 are discarded; regs[0] reads 0 always.
- Reset: at rising clk with reset=1, all 32 registers <= 0; a concurrent write is dropped (reset has priority).
- Reads: rs_data = regs[rs_addr], rt_data = regs[rt_addr], pure combinational, no read enable. Address 0 returns 0.
- Both read ports may address the same register; both return the same value.
- No stall or flush inputs: the MEM/WB register upstream controls bubbles by clearing RegWrite_WB.

## Timing
- Write latency: value presented at cycle N is architecturally visible in regs from cycle N+1.
- Read latency: zero cycles (combinational from address/array).
- Same-cycle write/read to same nonzero register: governed by the configuration macro.
- Outputs during/after reset: rs_data, rt_data = 0 for every address from the first edge with reset=1 until a write commits; wb_active = 0 while reset=1; WriteData_WB follows its inputs.
- Reset asserted mid-stream: the write in the reset cycle is lost; the first post-reset write occurs on the first edge with reset=0.

## Configuration
- REGFILE_BYPASS_EN defined: internal write-through. If wb_active and rs_addr (resp. rt_addr) equals RdOrRt_WB, rs_data (resp. rt_data) = WriteData_WB in the same cycle. This resolves the WB-to-ID hazard without stalling.
- Undefined: no bypass; reads return the pre-write register value until the cycle after commit. The hazard unit must stall decode one extra cycle on a WB/ID match.

## Test plan
- Reset then read all: reset=1 for one edge, sweep rs_addr/rt_addr 0..31 -> all read 0; wb_active=0 during reset.
- ALU write: RegWrite=1, MemtoReg=0, ALUResult=0x0000_1234, Rd=8; next cycle rs_addr=8 -> 0x0000_1234; WriteData_WB=0x0000_1234 in the write cycle.
- Load write and $0 protection: MemtoReg=1, dout=0xDEAD_BEEF, Rd=9 -> reg9=0xDEAD_BEEF. Then Rd=0, data 0xFFFF_FFFF -> rs_addr=0 reads 0, wb_active=0.
- Same-cycle hazard: reg10=0x11, then write 0x22 to reg10 while rs_addr=rt_addr=10 -> with REGFILE_BYPASS_EN both read 0x22 that cycle; without it both read 0x11; both read 0x22 next cycle.
- Reset vs. write: write 0x55 to reg12 in the same cycle as reset=1 -> reg12 reads 0 afterward. First write after deassert commits normally.
- Gated write: RegWrite=0, Rd=13, ALUResult=0x77 -> reg13 unchanged; WriteData_WB still 0x77.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback select and 32-entry architectural register file with two combinational read ports.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-through from the writeback port to the read ports.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] dout_WB,
  input  logic [DATA_W-1:0] ALUResult_WB,
  input  logic [ADDR_W-1:0] RdOrRt_WB,
  input  logic              RegWrite_WB,
  input  logic              MemtoReg_WB,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] WriteData_WB,
  output logic              wb_active
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    WriteData_WB = MemtoReg_WB ? dout_WB : ALUResult_WB;
    wb_active    = RegWrite_WB & (RdOrRt_WB != '0) & ~reset;
  end

  // Reset outranks a concurrent write; entry 0 is pinned to zero.
  always_comb begin
    regs_d = regs_q;
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_d[i] = '0;
    end else if (wb_active) begin
      regs_d[RdOrRt_WB] = WriteData_WB;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  always_comb begin
    rs_data = (rs_addr == '0) ? '0 : regs_q[rs_addr];
    rt_data = (rt_addr == '0) ? '0 : regs_q[rt_addr];
`ifdef REGFILE_BYPASS_EN
    // wb_active already excludes address 0, so the bypass never breaks the $0 rule.
    if (wb_active && (rs_addr == RdOrRt_WB)) rs_data = WriteData_WB;
    if (wb_active && (rt_addr == RdOrRt_WB)) rt_data = WriteData_WB;
`endif
  end

endmodule
